mandel_dispatch: RTL
====================

Name: mandel_dispatch

Overview:
- Frame-level scheduler for a bank of NUM_ITER Mandelbrot iterator cores.
- Walks a WIDTH x HEIGHT pixel grid and generates c = (c_r, c_i) in 4.23 signed fixed point.
- Hands each point to a free core over the cores' in_val/in_rdy handshake and collects iteration counts over out_val/out_rdy.
- Emits tagged pixel results (address, count) toward the VGA/SRAM writer.

Parameters:
- NUM_ITER, 4, number of iterator cores (1..16).
- WIDTH, 640, pixels per row.
- HEIGHT, 480, rows per frame.
- ITER_W, 11, width of a core's iter_count (clog2(ITER_MAX)+1).
- ADDR_W, 19, pixel address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- start  in  1  one-cycle pulse; begins a frame when idle
- cfg_x0  in  27  signed 4.23, c_r of column 0
- cfg_y0  in  27  signed 4.23, c_i of row 0
- cfg_step  in  27  signed 4.23, pixel pitch
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, frame complete
- it_in_val  out  NUM_ITER  per-core dispatch valid
- it_in_rdy  in  NUM_ITER  per-core idle/ready
- it_c_r  out  27  broadcast c_r
- it_c_i  out  27  broadcast c_i
- it_out_val  in  NUM_ITER  per-core result valid
- it_out_rdy  out  NUM_ITER  per-core result accept
- it_iter_count  in  NUM_ITER*ITER_W  packed counts; core k at [k*ITER_W +: ITER_W]
- pix_val  out  1  result valid
- pix_rdy  in  1  downstream ready
- pix_addr  out  ADDR_W  y*WIDTH + x
- pix_iter  out  ITER_W  iteration count

Behaviour:
- Interface decision: single clock clk; reset is asynchronous, active-high. All flops clear on reset assertion, regardless of clk.
- Reset values: busy=0, done=0, pix_val=0, pix_addr=0, pix_iter=0, it_in_val=0, it_out_rdy=0. Pointers, counters and coordinate registers are 0; state=IDLE.
- States:
  - IDLE: start -> SCAN. On start, latch cfg_*, set cur_r=cfg_x0, cur_i=cfg_y0, x=0, y=0, addr=0. start is ignored outside IDLE.
  - SCAN: dispatch points. After the last pixel (x=WIDTH-1, y=HEIGHT-1) is dispatched -> DRAIN.
  - DRAIN: wait until outstanding==0 and pix_val==0 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in SCAN, DRAIN and DONE.
- Dispatch (SCAN only):
  - Combinational grant picks the first core with it_in_rdy=1, searching from dispatch pointer dp upward with wrap.
  - it_in_val is one-hot on that core, zero if none is ready. it_c_r=cur_r and it_c_i=cur_i are driven continuously.
  - On a grant: tag[k]<=addr, dp<=k+1 mod NUM_ITER, outstanding++, advance the point.
  - Advance: x++, cur_r+=step. At x=WIDTH-1: x=0, cur_r=x0, y++, cur_i-=step (rows go downward). addr++.
  - Coordinate math is 27-bit two's-complement wrap, no saturation.
  - At most one dispatch per cycle.
- Collection (any state):
  - Output buffer is one entry (pix_val/pix_addr/pix_iter registers).
  - can_accept = !pix_val || pix_rdy.
  - When can_accept, a round-robin grant over it_out_val, starting at collect pointer cp, asserts it_out_rdy one-hot. Otherwise it_out_rdy=0.
  - On accept of core k: pix_val<=1, pix_addr<=tag[k], pix_iter<=count k, cp<=k+1 mod NUM_ITER, outstanding--.
  - pix_val && pix_rdy with no new accept -> pix_val<=0.
  - Sustained throughput: one result per cycle.
- Simultaneous dispatch and accept in the same cycle: outstanding is unchanged.
- outstanding is a clog2(NUM_ITER+1)-bit counter. It never exceeds NUM_ITER, since cores hold in_rdy low while busy.
- Results leave out of order; pix_addr identifies the pixel.
- Reset mid-frame aborts with no done pulse. The cores must share the same reset so no orphan results remain.

Optional Feature:
- Macro: MANDEL_DISPATCH_PERF_EN.
- With the macro:
  - Adds output perf_cycles [31:0], counting clk cycles while busy. It clears on accepted start and holds after done.
  - Adds output perf_stall [31:0], counting SCAN cycles with no core ready.
  - Both reset to 0.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- NUM_ITER=2, WIDTH=4, HEIGHT=2, x0=-2.0 (27'h7000000), y0=+1.0 (27'h0800000), step=0.5 (27'h0400000); cores modelled ready; start -> dispatched c sequence (-2,1),(-1.5,1),(-1,1),(-0.5,1),(-2,0.5)... Exactly 8 pix_val beats with addresses 0..7, each once, then one done pulse.
- Cores returning in reverse order (core1 before core0) -> pix_addr follows tags, not dispatch order; iter values match the model.
- pix_rdy held low 20 cycles mid-frame -> pix_val stays 1 with stable addr/iter, it_out_rdy=0, no result lost. After release, all remaining results arrive.
- Two cores raise out_val in the same cycle, cp=0 -> core0 accepted first, core1 on the next cycle; dispatch continues meanwhile.
- start pulsed during SCAN -> ignored; frame still produces exactly WIDTH*HEIGHT results.
- Async reset asserted mid-DRAIN between clock edges -> busy, pix_val and it_in_val go 0 immediately; no done. A following start runs a clean full frame.

Source files
------------

// File: rtl/mandel_dispatch.sv
// mandel_dispatch: walks a WIDTH x HEIGHT grid, dispatches c points to free iterator
// cores and collects tagged results. Define MANDEL_DISPATCH_PERF_EN for perf counters.
module mandel_dispatch #(
  parameter int NUM_ITER = 4,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int ITER_W   = 11,
  parameter int ADDR_W   = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [26:0]                cfg_x0,
  input  logic [26:0]                cfg_y0,
  input  logic [26:0]                cfg_step,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_ITER-1:0]        it_in_val,
  input  logic [NUM_ITER-1:0]        it_in_rdy,
  output logic [26:0]                it_c_r,
  output logic [26:0]                it_c_i,
  input  logic [NUM_ITER-1:0]        it_out_val,
  output logic [NUM_ITER-1:0]        it_out_rdy,
  input  logic [NUM_ITER*ITER_W-1:0] it_iter_count,
  output logic                       pix_val,
  input  logic                       pix_rdy,
  output logic [ADDR_W-1:0]          pix_addr,
  output logic [ITER_W-1:0]          pix_iter
`ifdef MANDEL_DISPATCH_PERF_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_stall
`endif
);

  localparam int PTR_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int CNT_W = $clog2(NUM_ITER + 1);
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // First requester at or above ptr, wrapping; returns ptr when nothing requests.
  function automatic logic [PTR_W-1:0] rr_first(input logic [NUM_ITER-1:0] req,
                                                 input logic [PTR_W-1:0]    ptr);
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] sel;
    logic             hit;
    sel = ptr;
    hit = 1'b0;
    for (int i = 0; i < NUM_ITER; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      idx = (sum >= (PTR_W+1)'(NUM_ITER)) ? PTR_W'(sum - (PTR_W+1)'(NUM_ITER)) : PTR_W'(sum);
      sel = (!hit && req[idx]) ? idx : sel;
      hit = hit | req[idx];
    end
    return sel;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] k);
    return (k == PTR_W'(NUM_ITER - 1)) ? {PTR_W{1'b0}} : k + PTR_W'(1);
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [26:0]         x0_r;
  logic [26:0]         step_r;
  logic [26:0]         cur_re_r;
  logic [26:0]         cur_im_r;
  logic [XW-1:0]       x_r;
  logic [YW-1:0]       y_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   tag_r [NUM_ITER];
  logic [PTR_W-1:0]    dp_r;
  logic [PTR_W-1:0]    cp_r;
  logic [CNT_W-1:0]    outstanding_r;
  logic [ITER_W-1:0]   count_s [NUM_ITER];
  logic                start_ok_s;
  logic                dsp_any_s;
  logic [PTR_W-1:0]    dsp_idx_s;
  logic                can_accept_s;
  logic                acc_any_s;
  logic [PTR_W-1:0]    acc_idx_s;
  logic                last_pix_s;

  assign start_ok_s   = (state_r == ST_IDLE) && start;
  assign dsp_any_s    = (state_r == ST_SCAN) && (|it_in_rdy);
  assign dsp_idx_s    = rr_first(it_in_rdy, dp_r);
  assign can_accept_s = !pix_val || pix_rdy;
  assign acc_any_s    = can_accept_s && (|it_out_val);
  assign acc_idx_s    = rr_first(it_out_val, cp_r);
  assign last_pix_s   = (x_r == X_LAST) && (y_r == Y_LAST);
  assign it_c_r       = cur_re_r;
  assign it_c_i       = cur_im_r;

  always_comb begin
    for (int k = 0; k < NUM_ITER; k++) begin
      count_s[k] = it_iter_count[k*ITER_W +: ITER_W];
    end
  end

  // One-hot handshakes toward the cores.
  always_comb begin
    it_in_val  = {NUM_ITER{1'b0}};
    it_out_rdy = {NUM_ITER{1'b0}};
    if (dsp_any_s) begin
      it_in_val[dsp_idx_s] = 1'b1;
    end else begin
      it_in_val = {NUM_ITER{1'b0}};
    end
    if (acc_any_s) begin
      it_out_rdy[acc_idx_s] = 1'b1;
    end else begin
      it_out_rdy = {NUM_ITER{1'b0}};
    end
  end

  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_SCAN;
        else       state_nx_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (dsp_any_s && last_pix_s) state_nx_s = ST_DRAIN;
        else                         state_nx_s = ST_SCAN;
      end
      ST_DRAIN: begin
        if ((outstanding_r == {CNT_W{1'b0}}) && !pix_val) state_nx_s = ST_DONE;
        else                                               state_nx_s = ST_DRAIN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != ST_IDLE);
      done    <= (state_nx_s == ST_DONE);
    end
  end

  // Point generator: rows advance downward, so c_i decreases by step per row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_r     <= 27'd0;
      step_r   <= 27'd0;
      cur_re_r <= 27'd0;
      cur_im_r <= 27'd0;
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      dp_r     <= {PTR_W{1'b0}};
      for (int k = 0; k < NUM_ITER; k++) begin
        tag_r[k] <= {ADDR_W{1'b0}};
      end
    end else if (start_ok_s) begin
      x0_r     <= cfg_x0;
      step_r   <= cfg_step;
      cur_re_r <= cfg_x0;
      cur_im_r <= cfg_y0;
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
    end else if (dsp_any_s) begin
      tag_r[dsp_idx_s] <= addr_r;
      dp_r             <= ptr_next(dsp_idx_s);
      addr_r           <= addr_r + ADDR_W'(1);
      if (x_r == X_LAST) begin
        x_r      <= {XW{1'b0}};
        y_r      <= y_r + YW'(1);
        cur_re_r <= x0_r;
        cur_im_r <= cur_im_r - step_r;
      end else begin
        x_r      <= x_r + XW'(1);
        cur_re_r <= cur_re_r + step_r;
      end
    end
  end

  // Single-entry result buffer toward the pixel writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_val  <= 1'b0;
      pix_addr <= {ADDR_W{1'b0}};
      pix_iter <= {ITER_W{1'b0}};
      cp_r     <= {PTR_W{1'b0}};
    end else if (acc_any_s) begin
      pix_val  <= 1'b1;
      pix_addr <= tag_r[acc_idx_s];
      pix_iter <= count_s[acc_idx_s];
      cp_r     <= ptr_next(acc_idx_s);
    end else if (pix_rdy) begin
      pix_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      case ({dsp_any_s, acc_any_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

`ifdef MANDEL_DISPATCH_PERF_EN
  // Frame length and cycles lost with every core occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      if (start_ok_s) begin
        perf_cycles <= 32'd0;
      end else if (state_r != ST_IDLE) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state_r == ST_SCAN) && !(|it_in_rdy)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
